postfix_eval: RTL

- Consumer end of the sign/number token stream produced by the infix-to-postfix converter.
- Evaluates the postfix (RPN) expression with an internal operand stack.
- Reports a single signed result, or an error code, when the end-of-expression marker arrives.
- Sits directly downstream of the converter; its token inputs wire to the converter's SIGN_OUT/SIGN_OUT_STB and NUMBER_OUT/NUMBER_OUT_STB.

---
 rtl/postfix_eval_if.sv | 15 +
 rtl/postfix_eval.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/postfix_eval_if.sv
// postfix_eval_if: token inputs from the infix-to-postfix converter and result outputs
interface postfix_eval_if #(parameter int WIDTH = 16);
    logic [7:0]       INPUT_NUMBER;
    logic             NUMBER_STB;
    logic [7:0]       INPUT_SIGN;
    logic             SIGN_STB;
    logic [WIDTH-1:0] RESULT;
    logic             RESULT_STB;
    logic [2:0]       ERR_CODE;
    logic             BUSY;
    modport master (output INPUT_NUMBER, NUMBER_STB, INPUT_SIGN, SIGN_STB,
                    input  RESULT, RESULT_STB, ERR_CODE, BUSY);
    modport slave  (input  INPUT_NUMBER, NUMBER_STB, INPUT_SIGN, SIGN_STB,
                    output RESULT, RESULT_STB, ERR_CODE, BUSY);
endinterface

// File: rtl/postfix_eval.sv
// postfix_eval: RPN evaluator with an operand stack, reporting result or error code on END.
// Define POSTFIX_DIV_EN to add the sequential signed divider for '/'.
module postfix_eval #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic CLK,
    input logic RST,
    postfix_eval_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] TWO = 2;
    localparam logic [AW:0] FULL = ONE << AW;
    typedef enum logic [2:0] {IDLE, EXEC, DIV, REPORT, ERR} state_t;
    state_t state_q, state_d;
    logic num_stb_q, sign_stb_q;
    logic [AW:0] sp_q, sp_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [7:0] op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0] code_q, code_d;
    logic end_pend_q, end_pend_d, ovr_q, ovr_d;
    logic num_tok, sign_tok, end_tok, busy, known;
    logic [AW-1:0] tp, nx;
    logic [WIDTH-1:0] a, b, arith;
    assign num_tok  = bus.NUMBER_STB & ~num_stb_q;
    assign sign_tok = bus.SIGN_STB & ~sign_stb_q;
    assign end_tok  = bus.NUMBER_STB & bus.SIGN_STB & (num_tok | sign_tok);
    assign busy     = (state_q == EXEC) || (state_q == DIV);
    assign known    = bus.INPUT_SIGN inside {8'd43, 8'd45, 8'd42, 8'd47};
    assign tp       = AW'(sp_q - ONE);
    assign nx       = AW'(sp_q - TWO);
    assign a        = stk_q[nx];
    assign b        = stk_q[tp];
    assign arith    = op_q == 8'd43 ? a + b : op_q == 8'd45 ? a - b : a * b;
`ifdef POSTFIX_DIV_EN
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, quot_n, rem_n;
    logic [CW-1:0] cnt_q, cnt_d;
    logic neg_q, neg_d;
    logic [WIDTH:0] r2, diff;
    // One restoring step per cycle on magnitudes; the sign is applied at the end.
    assign r2     = {rem_q, quot_q[WIDTH-1]};
    assign diff   = r2 - {1'b0, dvs_q};
    assign quot_n = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
    assign rem_n  = diff[WIDTH] ? r2[WIDTH-1:0] : diff[WIDTH-1:0];
`endif
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        stk_d      = stk_q;
        op_d       = op_q;
        result_d   = result_q;
        code_d     = code_q;
        end_pend_d = end_pend_q | (busy & end_tok);
        ovr_d      = busy & (ovr_q | ((num_tok | sign_tok) & ~end_tok));
`ifdef POSTFIX_DIV_EN
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (end_tok || end_pend_q) begin
                    end_pend_d = 1'b0;
                    result_d   = sp_q == ONE ? stk_q[0] : '0;
                    code_d     = sp_q == ONE ? 3'd0 : 3'd5;
                    state_d    = REPORT;
                end else if (num_tok) begin
                    code_d  = sp_q == FULL ? 3'd2 : 3'd0;
                    state_d = sp_q == FULL ? ERR : IDLE;
                    if (sp_q != FULL) begin
                        stk_d[sp_q[AW-1:0]] = WIDTH'(bus.INPUT_NUMBER);
                        sp_d = sp_q + ONE;
                    end
                end else if (sign_tok) begin
                    op_d    = bus.INPUT_SIGN;
                    code_d  = sp_q < TWO ? 3'd1 : !known ? 3'd3 : 3'd0;
                    state_d = (sp_q < TWO || !known) ? ERR : EXEC;
                end
            end
            EXEC: begin
                if (op_q == 8'd47) begin
`ifdef POSTFIX_DIV_EN
                    neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    quot_d  = a[WIDTH-1] ? -a : a;
                    dvs_d   = b[WIDTH-1] ? -b : b;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = DIV;
`else
                    code_d  = 3'd3;
                    state_d = ERR;
`endif
                end else begin
                    stk_d[nx] = arith;
                    sp_d      = sp_q - ONE;
                    code_d    = ovr_d ? 3'd6 : code_q;
                    state_d   = ovr_d ? ERR : IDLE;
                end
            end
`ifdef POSTFIX_DIV_EN
            DIV: begin
                if (dvs_q == '0) begin
                    code_d  = 3'd4;
                    state_d = ERR;
                end else begin
                    quot_d = quot_n;
                    rem_d  = rem_n;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        stk_d[nx] = neg_q ? -quot_n : quot_n;
                        sp_d      = sp_q - ONE;
                        code_d    = ovr_d ? 3'd6 : code_q;
                        state_d   = ovr_d ? ERR : IDLE;
                    end
                end
            end
`endif
            REPORT: begin
                sp_d    = '0;
                state_d = IDLE;
            end
            ERR: begin
                if (end_tok || end_pend_q) begin
                    end_pend_d = 1'b0;
                    result_d   = '0;
                    state_d    = REPORT;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            num_stb_q  <= 1'b0;
            sign_stb_q <= 1'b0;
            sp_q       <= '0;
            stk_q      <= '{default: '0};
            op_q       <= '0;
            result_q   <= '0;
            code_q     <= '0;
            end_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_stb_q  <= bus.NUMBER_STB;
            sign_stb_q <= bus.SIGN_STB;
            sp_q       <= sp_d;
            stk_q      <= stk_d;
            op_q       <= op_d;
            result_q   <= result_d;
            code_q     <= code_d;
            end_pend_q <= end_pend_d;
            ovr_q      <= ovr_d;
        end
    end
`ifdef POSTFIX_DIV_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
        end
    end
`endif
    assign bus.RESULT     = result_q;
    assign bus.RESULT_STB = state_q == REPORT;
    assign bus.ERR_CODE   = code_q;
    assign bus.BUSY       = state_q != IDLE;
endmodule
